mux_8_to_1: RTL and testbench



---
 rtl/mux_8_to_1_pkg.sv | 9 +
 rtl/mux_8_to_1_sel.sv | 19 +
 rtl/mux_8_to_1.sv | 49 ++++
 tb/tb_mux_8_to_1.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mux_8_to_1_pkg.sv
// Shared constants for the 8-to-1 registered multiplexer.
//   num_inputs : number of selectable data inputs
//   sel_width  : width of the binary select
package mux_8_to_1_pkg;

   localparam int unsigned NumInputs = 8;
   localparam int unsigned SelWidth  = 3;

endpackage

// File: rtl/mux_8_to_1_sel.sv
// Purely combinational 8:1 bit select.
// Ports:
//   data : data inputs; data[k] is chosen when sel == k
//   sel  : unsigned binary select, sel[2] is the MSB
//   y    : selected bit
module mux_8_to_1_sel
   import mux_8_to_1_pkg::*;
(
   input  logic [NumInputs-1:0] data,
   input  logic [SelWidth-1:0]  sel,
   output logic                 y
);

   // All 8 codes map to a valid input, so no default handling is needed.
   always_comb begin
      y = data[sel];
   end

endmodule

// File: rtl/mux_8_to_1.sv
// 8-input, 1-bit multiplexer with active-low enable and registered output.
// OUTPUT takes IN[S] one clock after sampling when enabled, else 0.
// Ports (positional order kept for existing instantiations):
//   IN     : data inputs, IN[k] selected when S == k
//   OUTPUT : registered mux output
//   S      : select, 0..7
//   EN_BAR : active-low enable (1 forces OUTPUT to 0)
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, highest priority
module mux_8_to_1
   import mux_8_to_1_pkg::*;
(
   input  logic [NumInputs-1:0] IN,
   output logic                 OUTPUT,
   input  logic [SelWidth-1:0]  S,
   input  logic                 EN_BAR,
   input  logic                 clk,
   input  logic                 rst
);

   logic sel_bit;
   logic output_d;
   logic output_q;

   mux_8_to_1_sel u_sel (
      .data (IN),
      .sel  (S),
      .y    (sel_bit)
   );

   // Priority: rst > EN_BAR > select; rst is handled in the register.
   always_comb begin
      output_d = 1'b0;
      if (!EN_BAR) begin
         output_d = sel_bit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         output_q <= 1'b0;
      end else begin
         output_q <= output_d;
      end
   end

   assign OUTPUT = output_q;

endmodule

// File: tb/tb_mux_8_to_1.sv
module tb_mux_8_to_1;

   logic [7:0] in_bits;
   logic       out_bit;
   logic [2:0] sel;
   logic       en_bar;
   logic       clk;
   logic       rst;

   typedef struct {
      logic  exp;
      string name;
   } exp_t;

   exp_t sb_q[$];
   int   passed = 0;
   int   total  = 0;
   bit   done   = 0;

   mux_8_to_1 dut (
      .IN     (in_bits),
      .OUTPUT (out_bit),
      .S      (sel),
      .EN_BAR (en_bar),
      .clk    (clk),
      .rst    (rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one vector at the falling edge; its result is due after the next rising edge.
   task automatic apply(input logic r, input logic eb, input logic [2:0] s,
                        input logic [7:0] d, input logic exp, input string name);
      exp_t e;
      @(negedge clk);
      rst     = r;
      en_bar  = eb;
      sel     = s;
      in_bits = d;
      e.exp   = exp;
      e.name  = name;
      sb_q.push_back(e);
   endtask

   // Monitor: output is registered, so it is sampled just after each rising edge.
   initial begin
      exp_t e;
      while (!done) begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (out_bit === e.exp) begin
               passed++;
            end else begin
               $display("FAIL %s: OUTPUT=%b expected=%b", e.name, out_bit, e.exp);
            end
         end
      end
   end

   initial begin
      logic [7:0] pat_ab;
      logic [7:0] exp_ab;
      rst     = 1'b1;
      en_bar  = 1'b0;
      sel     = 3'd0;
      in_bits = 8'hFF;
      pat_ab  = 8'hAB;
      // Hand-computed bits of 8'hAB for S = 0..7.
      exp_ab  = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

      // Reset held two cycles with enabled, all-ones data.
      apply(1'b1, 1'b0, 3'd0, 8'hFF, 1'b0, "reset_0");
      apply(1'b1, 1'b0, 3'd0, 8'hFF, 1'b0, "reset_1");

      // Disabled sweep.
      for (int i = 0; i < 8; i++) begin
         apply(1'b0, 1'b1, 3'(i), pat_ab, 1'b0, $sformatf("disabled_s%0d", i));
      end

      // Enabled sweep: expected 1,1,0,1,0,1,0,1.
      for (int i = 0; i < 8; i++) begin
         apply(1'b0, 1'b0, 3'(i), pat_ab, exp_ab[i], $sformatf("enabled_s%0d", i));
      end

      // Enable toggle at S = 3.
      apply(1'b0, 1'b1, 3'd3, 8'hAB, 1'b0, "en_toggle_off0");
      apply(1'b0, 1'b0, 3'd3, 8'hAB, 1'b1, "en_toggle_on");
      apply(1'b0, 1'b1, 3'd3, 8'hAB, 1'b0, "en_toggle_off1");

      // Data change at fixed S = 5.
      apply(1'b0, 1'b0, 3'd5, 8'h20, 1'b1, "data_20_a");
      apply(1'b0, 1'b0, 3'd5, 8'hDF, 1'b0, "data_df");
      apply(1'b0, 1'b0, 3'd5, 8'h20, 1'b1, "data_20_b");
      apply(1'b0, 1'b0, 3'd5, 8'h20, 1'b1, "data_hold");

      // MSB select edge and simultaneous changes.
      apply(1'b0, 1'b0, 3'd7, 8'h80, 1'b1, "msb_80");
      apply(1'b0, 1'b0, 3'd7, 8'h7F, 1'b0, "msb_7f");
      apply(1'b0, 1'b0, 3'd0, 8'hFE, 1'b0, "lsb_fe");

      // Reset mid-operation.
      apply(1'b0, 1'b0, 3'd0, 8'h01, 1'b1, "mid_pre");
      apply(1'b1, 1'b0, 3'd0, 8'h01, 1'b0, "mid_rst");
      apply(1'b0, 1'b0, 3'd0, 8'h01, 1'b1, "mid_post");

      // Bounded drain of the scoreboard.
      for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      if (sb_q.size() > 0) begin
         total++;
         $display("FAIL drain: pending=%0d expected=0", sb_q.size());
      end
      done = 1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
